// File: rtl/pe_array_sequencer.sv
// Row sequencer: clears, streams kernel then neuron words into each PE column,
// then runs the MAC phase and a fixed pipeline drain before pulsing done.
module pe_array_sequencer #(
  parameter int A     = 7,
  parameter int W     = 16,
  parameter int COLS  = 4,
  parameter int DRAIN = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [A:0]        kernelLen,
  input  logic [A:0]        neuronLen,
  input  logic [A:0]        macLen,
  input  logic              poolCfg,
  input  logic              inValid,
  input  logic [W-1:0]      inData,
  output logic              inReady,
  output logic [W-1:0]      kernelIn,
  output logic [W-1:0]      neuronIn,
  output logic [8*COLS-1:0] columnControl,
  output logic              doPooling,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(COLS + 1);
  localparam int DW = $clog2(DRAIN + 1);

  // column byte = {clrAddr, incK, incN, 3'b0, kernelWrite, neuronWrite}
  localparam logic [7:0] CTL_CLR = 8'h80;
  localparam logic [7:0] CTL_KWR = 8'h42;
  localparam logic [7:0] CTL_NWR = 8'h21;
  localparam logic [7:0] CTL_MAC = 8'h60;
  localparam logic [A:0] LEN_MAX = {1'b1, {A{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LOAD_K, S_LOAD_N, S_MAC, S_DRAIN, S_DONE
  } state_t;

  function automatic logic [A:0] clamp_len(input logic [A:0] len);
    return (len > LEN_MAX) ? LEN_MAX : len;
  endfunction

  // Columns outside 0..COLS-1 map to nothing, so col==COLS yields all zeros.
  function automatic logic [8*COLS-1:0] col_byte(input logic [CW-1:0] col, input logic [7:0] b);
    logic [8*COLS-1:0] v;
    v = '0;
    for (int c = 0; c < COLS; c++)
      if (CW'(c) == col) v[8*c +: 8] = b;
    return v;
  endfunction

  state_t            r_state, w_state;
  logic [CW-1:0]     r_col, w_col;
  logic [A:0]        r_cnt, w_cnt;
  logic [DW-1:0]     r_dcnt, w_dcnt;
  logic [A:0]        r_klen, w_klen, r_nlen, w_nlen, r_mlen, w_mlen;
  logic [A:0]        w_len;
  logic              r_inready, w_inready;
  logic [W-1:0]      r_kdat, w_kdat, r_ndat, w_ndat;
  logic [8*COLS-1:0] r_ctl, w_ctl;
  logic              r_pool, w_pool, r_busy, w_busy, r_done, w_done;
  logic              w_hs;

  assign w_hs = inValid & r_inready;

  // Next values describe what the outputs show in the following cycle.
  always_comb begin
    w_state   = r_state;
    w_col     = r_col;
    w_cnt     = r_cnt;
    w_dcnt    = r_dcnt;
    w_klen    = r_klen;
    w_nlen    = r_nlen;
    w_mlen    = r_mlen;
    w_len     = (r_state == S_LOAD_K) ? r_klen : r_nlen;
    w_inready = r_inready;
    w_kdat    = r_kdat;
    w_ndat    = r_ndat;
    w_ctl     = '0;
    w_pool    = r_pool;
    w_busy    = r_busy;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state = S_CLR;
          w_klen  = clamp_len(kernelLen);
          w_nlen  = clamp_len(neuronLen);
          w_mlen  = clamp_len(macLen);
          w_pool  = poolCfg;
          w_busy  = 1'b1;
          w_ctl   = {COLS{CTL_CLR}};
        end
      end
      S_CLR: begin
        w_col = '0;
        w_cnt = '0;
        if (r_klen != '0) begin
          w_state   = S_LOAD_K;
          w_inready = 1'b1;
        end else if (r_nlen != '0) begin
          w_state   = S_LOAD_N;
          w_inready = 1'b1;
        end else if (r_mlen != '0) begin
          w_state = S_MAC;
          w_ctl   = {COLS{CTL_MAC}};
          w_cnt   = (A+1)'(1);
        end else begin
          w_state = S_DRAIN;
          w_dcnt  = DW'(1);
        end
      end
      S_LOAD_K, S_LOAD_N: begin
        if (r_col == CW'(COLS)) begin
          // Tail cycle: the final write is on the bus, addresses get re-cleared for MAC.
          w_cnt = '0;
          if (r_mlen != '0) begin
            w_state = S_MAC;
            w_ctl   = {COLS{CTL_CLR}};
          end else begin
            w_state = S_DRAIN;
            w_dcnt  = DW'(1);
          end
        end else if (w_hs) begin
          if (r_state == S_LOAD_K) begin
            w_kdat = inData;
            w_ctl  = col_byte(r_col, CTL_KWR);
          end else begin
            w_ndat = inData;
            w_ctl  = col_byte(r_col, CTL_NWR);
          end
          w_cnt = r_cnt + 1'b1;
          if (w_cnt == w_len) begin
            w_cnt = '0;
            w_col = r_col + 1'b1;
            if (r_col != CW'(COLS - 1)) begin
              w_ctl = w_ctl | col_byte(w_col, CTL_CLR);
            end else if (r_state == S_LOAD_K && r_nlen != '0) begin
              w_state = S_LOAD_N;
              w_col   = '0;
              w_ctl   = w_ctl | col_byte('0, CTL_CLR);
            end else begin
              w_state   = S_LOAD_N;
              w_inready = 1'b0;
            end
          end
        end
      end
      S_MAC: begin
        if (r_cnt == r_mlen) begin
          w_state = S_DRAIN;
          w_dcnt  = DW'(1);
        end else begin
          w_ctl = {COLS{CTL_MAC}};
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_dcnt == DW'(DRAIN)) begin
          w_state = S_DONE;
          w_done  = 1'b1;
          w_busy  = 1'b0;
        end else begin
          w_dcnt = r_dcnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_pool  = 1'b0;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_col     <= '0;
      r_cnt     <= '0;
      r_dcnt    <= '0;
      r_klen    <= '0;
      r_nlen    <= '0;
      r_mlen    <= '0;
      r_inready <= 1'b0;
      r_kdat    <= '0;
      r_ndat    <= '0;
      r_ctl     <= '0;
      r_pool    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_col     <= w_col;
      r_cnt     <= w_cnt;
      r_dcnt    <= w_dcnt;
      r_klen    <= w_klen;
      r_nlen    <= w_nlen;
      r_mlen    <= w_mlen;
      r_inready <= w_inready;
      r_kdat    <= w_kdat;
      r_ndat    <= w_ndat;
      r_ctl     <= w_ctl;
      r_pool    <= w_pool;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
  end

  assign inReady       = r_inready;
  assign kernelIn      = r_kdat;
  assign neuronIn      = r_ndat;
  assign columnControl = r_ctl;
  assign doPooling     = r_pool;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Directed bench for pe_array_sequencer (A=7, W=16, COLS=4, DRAIN=2).
module tb_pe_array_sequencer;
  logic        CLK;
  logic        RST_N;
  logic        start;
  logic [7:0]  kernelLen, neuronLen, macLen;
  logic        poolCfg;
  logic        inValid;
  logic [15:0] inData;
  logic        inReady;
  logic [15:0] kernelIn, neuronIn;
  logic [31:0] columnControl;
  logic        doPooling, busy, done;

  pe_array_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .start(start),
    .kernelLen(kernelLen), .neuronLen(neuronLen), .macLen(macLen),
    .poolCfg(poolCfg), .inValid(inValid), .inData(inData), .inReady(inReady),
    .kernelIn(kernelIn), .neuronIn(neuronIn), .columnControl(columnControl),
    .doPooling(doPooling), .busy(busy), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  // Observations gathered by run_job; cycle 1 is the first cycle after start is sampled.
  int kw[4], nw[4];
  int kwr_total, nwr_total, order_err, byte_err, data_err, bubble_wr, missed_wr;
  int inck_total, mac_cyc, last_mac_cyc, last_nw_cyc, done_cnt, done_cyc, pool_cyc, acc_total;
  logic busy_c1, pool_c1, busy_at_done, pool_after;
  logic [31:0] clr_c1;

  task automatic run_job(input int k, input int n, input int m, input bit pool,
                         input bit toggle, input bit restart);
    int cyc, post;
    bit hs, prev_hs, wr_k, wr_n;
    logic [7:0] b;
    logic [15:0] kq[$], nq[$];
    logic [15:0] exp_w;
    for (int c = 0; c < 4; c++) begin kw[c] = 0; nw[c] = 0; end
    kwr_total = 0; nwr_total = 0; order_err = 0; byte_err = 0; data_err = 0;
    bubble_wr = 0; missed_wr = 0; inck_total = 0; mac_cyc = 0; last_mac_cyc = -1;
    last_nw_cyc = -1; done_cnt = 0; done_cyc = -1; pool_cyc = 0; acc_total = 0;
    busy_c1 = 1'bx; pool_c1 = 1'bx; busy_at_done = 1'bx; pool_after = 1'bx; clr_c1 = 'x;
    kernelLen = 8'(k); neuronLen = 8'(n); macLen = 8'(m); poolCfg = pool;
    start = 1'b1; inValid = 1'b0; inData = 16'h0;
    cyc = 0; post = -1; prev_hs = 1'b0;
    while (cyc < 400 && post != 0) begin
      @(posedge CLK); #1;
      cyc++;
      start = restart && (cyc == 5);
      if (start) begin
        kernelLen = 8'd1; neuronLen = 8'd1; macLen = 8'd1; poolCfg = ~pool;
      end
      wr_k = 1'b0; wr_n = 1'b0;
      for (int c = 0; c < 4; c++) begin
        b = columnControl[8*c +: 8];
        if (b[1]) begin
          kw[c]++; wr_k = 1'b1;
          if (k > 0 && c != kwr_total / k) order_err++;
          if (b != 8'h42) byte_err++;
          kwr_total++;
        end
        if (b[0]) begin
          nw[c]++; wr_n = 1'b1;
          if (n > 0 && c != nwr_total / n) order_err++;
          if (b != 8'h21) byte_err++;
          nwr_total++;
        end
        if (b[6]) inck_total++;
      end
      if (wr_k) begin
        if (kq.size() == 0) data_err++;
        else begin exp_w = kq.pop_front(); if (kernelIn !== exp_w) data_err++; end
      end
      if (wr_n) begin
        last_nw_cyc = cyc;
        if (nq.size() == 0) data_err++;
        else begin exp_w = nq.pop_front(); if (neuronIn !== exp_w) data_err++; end
      end
      if ((wr_k || wr_n) && !prev_hs) bubble_wr++;
      if (!(wr_k || wr_n) && prev_hs) missed_wr++;
      if (columnControl == {4{8'h60}}) begin mac_cyc++; last_mac_cyc = cyc; end
      if (doPooling) pool_cyc++;
      if (cyc == 1) begin busy_c1 = busy; pool_c1 = doPooling; clr_c1 = columnControl; end
      if (done_cyc >= 0 && cyc == done_cyc + 1) pool_after = doPooling;
      if (done) begin
        done_cnt++; done_cyc = cyc; busy_at_done = busy; post = 3;
      end else if (post > 0) post--;
      inValid = toggle ? cyc[0] : 1'b1;
      inData = 16'h1000 + 16'(cyc);
      hs = inReady && inValid;
      if (hs) begin
        if (acc_total < 4 * k) kq.push_back(inData);
        else nq.push_back(inData);
        acc_total++;
      end
      prev_hs = hs;
    end
    inValid = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; start = 1'b0; kernelLen = '0; neuronLen = '0; macLen = '0;
    poolCfg = 1'b0; inValid = 1'b0; inData = '0;
    #2;
    n_total++; if (inReady !== 1'b0) $display("FAIL reset_inReady: got %b, expected 0", inReady); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b, expected 0", done); else n_pass++;
    n_total++; if (doPooling !== 1'b0) $display("FAIL reset_doPooling: got %b, expected 0", doPooling); else n_pass++;
    n_total++; if (columnControl !== 32'h0) $display("FAIL reset_columnControl: got %h, expected 0", columnControl); else n_pass++;
    n_total++; if (kernelIn !== 16'h0 || neuronIn !== 16'h0)
      $display("FAIL reset_data: got %h/%h, expected 0/0", kernelIn, neuronIn); else n_pass++;
    @(posedge CLK); #1; RST_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_basic();
    run_job(3, 2, 5, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      n_total++; if (kw[c] !== 3 || nw[c] !== 2)
        $display("FAIL basic_writes_col%0d: got k=%0d n=%0d, expected k=3 n=2", c, kw[c], nw[c]); else n_pass++;
    end
    n_total++; if (order_err !== 0 || byte_err !== 0)
      $display("FAIL basic_order: got order_err=%0d byte_err=%0d, expected 0/0", order_err, byte_err); else n_pass++;
    n_total++; if (data_err !== 0) $display("FAIL basic_data: got %0d bad words, expected 0", data_err); else n_pass++;
    n_total++; if (clr_c1 !== 32'h80808080) $display("FAIL basic_clr: got %h, expected 80808080", clr_c1); else n_pass++;
    n_total++; if (busy_c1 !== 1'b1) $display("FAIL basic_busy_clr: got %b, expected 1", busy_c1); else n_pass++;
    n_total++; if (mac_cyc !== 5) $display("FAIL basic_mac_cycles: got %0d, expected 5", mac_cyc); else n_pass++;
    n_total++; if (inck_total !== 32) $display("FAIL basic_incK_total: got %0d, expected 32", inck_total); else n_pass++;
    n_total++; if (done_cyc - last_mac_cyc !== 3)
      $display("FAIL basic_drain: got %0d, expected 3", done_cyc - last_mac_cyc); else n_pass++;
    n_total++; if (done_cnt !== 1 || done_cyc !== 31)
      $display("FAIL basic_done: got count=%0d cycle=%0d, expected 1/31", done_cnt, done_cyc); else n_pass++;
    n_total++; if (busy_at_done !== 1'b0) $display("FAIL basic_busy_done: got %b, expected 0", busy_at_done); else n_pass++;
    n_total++; if (acc_total !== 20) $display("FAIL basic_accepted: got %0d, expected 20", acc_total); else n_pass++;
  endtask

  task automatic test_bubbles();
    run_job(3, 2, 5, 0, 1, 0);
    for (int c = 0; c < 4; c++) begin
      n_total++; if (kw[c] !== 3 || nw[c] !== 2)
        $display("FAIL bubble_writes_col%0d: got k=%0d n=%0d, expected k=3 n=2", c, kw[c], nw[c]); else n_pass++;
    end
    n_total++; if (data_err !== 0) $display("FAIL bubble_data: got %0d bad words, expected 0", data_err); else n_pass++;
    n_total++; if (bubble_wr !== 0 || missed_wr !== 0)
      $display("FAIL bubble_write_timing: got extra=%0d missing=%0d, expected 0/0", bubble_wr, missed_wr); else n_pass++;
    n_total++; if (done_cnt !== 1 || done_cyc !== 51)
      $display("FAIL bubble_done: got count=%0d cycle=%0d, expected 1/51", done_cnt, done_cyc); else n_pass++;
  endtask

  task automatic test_zero_kernel();
    run_job(0, 4, 0, 0, 0, 0);
    n_total++; if (kwr_total !== 0 || inck_total !== 0)
      $display("FAIL zk_no_kernel: got writes=%0d incK=%0d, expected 0/0", kwr_total, inck_total); else n_pass++;
    n_total++; if (nwr_total !== 16 || order_err !== 0)
      $display("FAIL zk_neuron_writes: got %0d order_err=%0d, expected 16/0", nwr_total, order_err); else n_pass++;
    n_total++; if (mac_cyc !== 0) $display("FAIL zk_mac_skipped: got %0d, expected 0", mac_cyc); else n_pass++;
    n_total++; if (done_cyc - last_nw_cyc !== 3 || done_cyc !== 21)
      $display("FAIL zk_done_timing: got gap=%0d cycle=%0d, expected 3/21", done_cyc - last_nw_cyc, done_cyc); else n_pass++;
  endtask

  task automatic test_start_while_busy();
    run_job(3, 2, 5, 0, 0, 1);
    n_total++; if (done_cnt !== 1 || done_cyc !== 31)
      $display("FAIL restart_done: got count=%0d cycle=%0d, expected 1/31", done_cnt, done_cyc); else n_pass++;
    n_total++; if (kwr_total !== 12 || nwr_total !== 8 || mac_cyc !== 5)
      $display("FAIL restart_lengths: got k=%0d n=%0d mac=%0d, expected 12/8/5", kwr_total, nwr_total, mac_cyc); else n_pass++;
    n_total++; if (pool_cyc !== 0) $display("FAIL restart_pool: got %0d, expected 0", pool_cyc); else n_pass++;
  endtask

  task automatic test_pooling();
    run_job(1, 1, 3, 1, 0, 0);
    n_total++; if (pool_c1 !== 1'b1) $display("FAIL pool_clr: got %b, expected 1", pool_c1); else n_pass++;
    n_total++; if (pool_cyc !== 17) $display("FAIL pool_cycles: got %0d, expected 17", pool_cyc); else n_pass++;
    n_total++; if (pool_after !== 1'b0) $display("FAIL pool_idle: got %b, expected 0", pool_after); else n_pass++;
    n_total++; if (done_cyc !== 17 || mac_cyc !== 3)
      $display("FAIL pool_job: got done=%0d mac=%0d, expected 17/3", done_cyc, mac_cyc); else n_pass++;
  endtask

  task automatic test_zero_all();
    run_job(0, 0, 0, 0, 0, 0);
    n_total++; if (done_cyc !== 4 || done_cnt !== 1)
      $display("FAIL zero_all_done: got cycle=%0d count=%0d, expected 4/1", done_cyc, done_cnt); else n_pass++;
    n_total++; if (acc_total !== 0 || inck_total !== 0)
      $display("FAIL zero_all_idle: got accepted=%0d incK=%0d, expected 0/0", acc_total, inck_total); else n_pass++;
  endtask

  task automatic test_mac_clamp();
    run_job(0, 0, 200, 0, 0, 0);
    n_total++; if (mac_cyc !== 128) $display("FAIL clamp_mac: got %0d, expected 128", mac_cyc); else n_pass++;
    n_total++; if (done_cyc !== 132) $display("FAIL clamp_done: got %0d, expected 132", done_cyc); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dn;
    kernelLen = 8'd3; neuronLen = 8'd2; macLen = 8'd5; poolCfg = 1'b1;
    start = 1'b1; inValid = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge CLK); #1;
      start = 1'b0;
      inData = 16'h2000 + 16'(c);
    end
    n_total++; if (inReady !== 1'b1 || doPooling !== 1'b1)
      $display("FAIL midrst_pre: got ready=%b pool=%b, expected 1/1", inReady, doPooling); else n_pass++;
    #2; RST_N = 1'b0; #1;
    n_total++; if (inReady !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || doPooling !== 1'b0)
      $display("FAIL midrst_ctrl: got ready=%b busy=%b done=%b pool=%b, expected 0", inReady, busy, done, doPooling); else n_pass++;
    n_total++; if (columnControl !== 32'h0 || kernelIn !== 16'h0 || neuronIn !== 16'h0)
      $display("FAIL midrst_data: got ctl=%h k=%h n=%h, expected 0", columnControl, kernelIn, neuronIn); else n_pass++;
    repeat (3) @(posedge CLK);
    #1; RST_N = 1'b1;
    dn = 0;
    repeat (60) begin
      @(posedge CLK); #1;
      if (done) dn++;
    end
    n_total++; if (dn !== 0) $display("FAIL midrst_no_done: got %0d pulses, expected 0", dn); else n_pass++;
    inValid = 1'b0;
    run_job(3, 2, 5, 0, 0, 0);
    n_total++; if (done_cnt !== 1 || done_cyc !== 31 || kwr_total !== 12 || nwr_total !== 8)
      $display("FAIL midrst_rerun: got done=%0d@%0d k=%0d n=%0d, expected 1@31 12 8",
               done_cnt, done_cyc, kwr_total, nwr_total); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_zero_kernel();
    test_start_while_busy();
    test_pooling();
    test_zero_all();
    test_mac_clamp();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
